// File: rtl/regfile_mp_if.sv
// Register file access bus: write port, two read ports, bulk-clear control and status.
interface regfile_mp_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 8
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);

   logic              WRT_EN_i;
   logic [ADDR_W-1:0] WRT_DEST_i;
   logic [DATA_W-1:0] WRT_DATA_i;
   logic [ADDR_W-1:0] RD_ADDR1_i;
   logic [ADDR_W-1:0] RD_ADDR2_i;
   logic [DATA_W-1:0] RD_DATA1_o;
   logic [DATA_W-1:0] RD_DATA2_o;
   logic              CLR_i;
   logic              BUSY_o;
   logic              CLR_DONE_o;
   logic              WRT_ERR_o;

   // Requester side (decode/writeback)
   modport master (
      output WRT_EN_i, WRT_DEST_i, WRT_DATA_i, RD_ADDR1_i, RD_ADDR2_i, CLR_i,
      input  RD_DATA1_o, RD_DATA2_o, BUSY_o, CLR_DONE_o, WRT_ERR_o
   );

   // Register file side
   modport slave (
      input  WRT_EN_i, WRT_DEST_i, WRT_DATA_i, RD_ADDR1_i, RD_ADDR2_i, CLR_i,
      output RD_DATA1_o, RD_DATA2_o, BUSY_o, CLR_DONE_o, WRT_ERR_o
   );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional zero entry, write bypass,
// range checking and a one-entry-per-cycle bulk-clear engine.
module regfile_mp #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned DEPTH    = 8,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input logic         CLK_i,
   input logic         RST_i,
   regfile_mp_if.slave bus
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);
   // One extra bit so DEPTH itself is representable for range compares.
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
   // DEPTH-1 always fits in ADDR_W bits, so the clear counter needs no extra bit.
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              dest_ok;
   logic              dest_zero;
   logic              wr_acc;
   logic              clear_en;
   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_data [2];

   // Write qualification: only in IDLE, in range, and not into the hardwired zero entry
   always_comb begin
      dest_ok   = ({1'b0, bus.WRT_DEST_i} < DEPTH_X);
      dest_zero = ZERO_REG && (bus.WRT_DEST_i == '0);
      wr_acc    = bus.WRT_EN_i && (state_q == ST_IDLE) && dest_ok && !dest_zero;
      clear_en  = (state_q == ST_CLEAR);
   end

   // Clear FSM next-state, counter and status pulses
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = bus.WRT_EN_i && ((state_q == ST_CLEAR) || !dest_ok);
      case (state_q)
         ST_IDLE: begin
            if (bus.CLR_i) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state, counter and status registers
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Storage array: clear engine and accepted writes are mutually exclusive by state
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (clear_en && (cnt_q == ADDR_W'(i))) begin
               mem_q[i] <= '0;
            end else if (wr_acc && (bus.WRT_DEST_i == ADDR_W'(i))) begin
               mem_q[i] <= bus.WRT_DATA_i;
            end
         end
      end
   end

   // Combinational read ports: range check, zero entry, bypass, then array
   always_comb begin
      rd_addr[0] = bus.RD_ADDR1_i;
      rd_addr[1] = bus.RD_ADDR2_i;
      for (int unsigned p = 0; p < 2; p++) begin
         rd_data[p] = '0;
         if ({1'b0, rd_addr[p]} >= DEPTH_X) begin
            rd_data[p] = '0;
         end else if (ZERO_REG && (rd_addr[p] == '0)) begin
            rd_data[p] = '0;
         end else if (BYPASS && wr_acc && (bus.WRT_DEST_i == rd_addr[p])) begin
            rd_data[p] = bus.WRT_DATA_i;
         end else begin
            rd_data[p] = mem_q[rd_addr[p]];
         end
      end
   end

   assign bus.RD_DATA1_o = rd_data[0];
   assign bus.RD_DATA2_o = rd_data[1];
   assign bus.BUSY_o     = (state_q == ST_CLEAR);
   assign bus.CLR_DONE_o = done_q;
   assign bus.WRT_ERR_o  = err_q;

endmodule
